// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset defaults, PC step, fetch FSM states
// and the PC alignment helper.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    // Instructions are word aligned; the two low address bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline holding register: loads a fetched word, holds it, or flushes
// it to the NOP slot on a redirect (flush wins over load).
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid
);

    logic [31:0] instr_r;
    logic [31:0] pc_out_r;
    logic        valid_r;

    // Slot register: flush, load or hold; PC_out keeps its last value on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r  <= NOP_INSTR;
            pc_out_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end else if (flush) begin
            instr_r  <= NOP_INSTR;
            valid_r  <= 1'b0;
        end else if (load) begin
            instr_r  <= instr_in;
            pc_out_r <= pc_in;
            valid_r  <= 1'b1;
        end
    end

    assign instruction = instr_r;
    assign pc_out      = pc_out_r;
    assign valid       = valid_r;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch FSM (IDLE/FETCH/STALL) and the
// instruction-memory handshake feeding the IF/ID holding register.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Br_taken,
    input  logic [31:0] Br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC_out,
    output logic        valid
);

    fetch_state_e state_r;
    fetch_state_e next_state_s;
    logic [31:0]  pc_r;
    logic [31:0]  next_pc_s;
    logic [31:0]  pc_plus_s;
    logic         imem_req_s;
    logic         load_s;

    // Next-state and request decode; a redirect overrides both stall and fetch.
    always_comb begin
        next_state_s = state_r;
        imem_req_s   = 1'b0;
        case (state_r)
            IDLE: begin
                next_state_s = FETCH;
            end
            FETCH: begin
                if (Br_taken) begin
                    next_state_s = FETCH;
                end else if (freeze) begin
                    next_state_s = STALL;
                end else begin
                    next_state_s = FETCH;
                    imem_req_s   = 1'b1;
                end
            end
            STALL: begin
                if (Br_taken) begin
                    next_state_s = FETCH;
                end else if (freeze) begin
                    next_state_s = STALL;
                end else begin
                    next_state_s = FETCH;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign load_s    = imem_req_s & imem_ack;
    assign pc_plus_s = pc_r + PC_STEP;

    // Next PC: redirect target, sequential advance on an accepted fetch, or hold.
    always_comb begin
        next_pc_s = pc_r;
        if (Br_taken) begin
            next_pc_s = align_pc(Br_addr);
        end else if (load_s) begin
            next_pc_s = pc_plus_s;
        end else begin
            next_pc_s = pc_r;
        end
    end

    // FSM state and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            pc_r    <= align_pc(RESET_PC);
        end else begin
            state_r <= next_state_s;
            pc_r    <= next_pc_s;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst),
        .load        (load_s),
        .flush       (Br_taken),
        .instr_in    (imem_rdata),
        .pc_in       (pc_plus_s),
        .instruction (Instruction),
        .pc_out      (PC_out),
        .valid       (valid)
    );

    assign imem_req  = imem_req_s;
    assign imem_addr = pc_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: sequential fetch, freeze,
// redirect priority, slow memory, PC wrap and asynchronous reset.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC_out;
    logic        valid;

    int errors = 0;
    int checks = 0;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .Br_taken    (Br_taken),
        .Br_addr     (Br_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .PC_out      (PC_out),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] ins, input logic [31:0] pco,
                            input logic vld, input logic [31:0] addr);
        chk({tag, "_instr"}, Instruction, ins);
        chk({tag, "_pcout"}, PC_out, pco);
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, vld});
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        rst        = 1'b1;
        freeze     = 1'b0;
        Br_taken   = 1'b0;
        Br_addr    = 32'h0000_0000;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0000_0000;
        #1;
        rst = 1'b0;
        #2;
        // reset state before any clock edge
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk_slot("rst", NOP, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr0", imem_addr, 32'h0);

        // back-to-back acks
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0000;
        tick();
        chk_slot("seq0", 32'hA000_0000, 32'h4, 1'b1, 32'h4);
        imem_rdata = 32'hA000_0001;
        tick();
        chk_slot("seq1", 32'hA000_0001, 32'h8, 1'b1, 32'h8);
        imem_rdata = 32'hA000_0002;
        tick();
        chk_slot("seq2", 32'hA000_0002, 32'hC, 1'b1, 32'hC);

        // freeze for 3 cycles with a stray ack present
        freeze     = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("frz_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_req_hold", {31'd0, imem_req}, 32'd0);
            chk_slot("frz", 32'hA000_0002, 32'hC, 1'b1, 32'hC);
        end
        freeze   = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("stall_exit_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'hC);
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0003;
        tick();
        chk_slot("refetch", 32'hA000_0003, 32'h10, 1'b1, 32'h10);

        // slow memory: five cycles without ack
        imem_ack   = 1'b0;
        imem_rdata = 32'hCAFE_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("slow_req", {31'd0, imem_req}, 32'd1);
            chk_slot("slow", 32'hA000_0003, 32'h10, 1'b1, 32'h10);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0004;
        tick();
        chk_slot("slow_ack", 32'hA000_0004, 32'h14, 1'b1, 32'h14);

        // redirect beats both freeze and a simultaneous ack
        Br_taken   = 1'b1;
        Br_addr    = 32'h0000_0103;
        freeze     = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("br_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk_slot("br", NOP, 32'h14, 1'b0, 32'h100);
        Br_taken = 1'b0;
        freeze   = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("br_fetch_req", {31'd0, imem_req}, 32'd1);

        // PC wrap at the top of the address space
        Br_taken = 1'b1;
        Br_addr  = 32'hFFFF_FFFF;
        tick();
        chk("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
        Br_taken   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0005;
        tick();
        chk_slot("wrap", 32'hA000_0005, 32'h0, 1'b1, 32'h0);

        // asynchronous reset during an acked fetch
        imem_rdata = 32'hEEEE_EEEE;
        #1;
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk_slot("arst", NOP, 32'h0, 1'b0, 32'h0);
        tick();
        chk_slot("arst_edge", NOP, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rel_fetch_req", {31'd0, imem_req}, 32'd1);
        chk_slot("rel_idle", NOP, 32'h0, 1'b0, 32'h0);
        imem_rdata = 32'hA000_0006;
        tick();
        chk_slot("rel_fetch", 32'hA000_0006, 32'h4, 1'b1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
